// File: rtl/sram_like_pkg.sv
// Shared types for the SRAM-like responder: access sizes and response FIFO entries.
package sram_like_pkg;

    localparam int unsigned DATA_W = 32;
    // Wide enough for any practical LATENCY (up to 256 cycles).
    localparam int unsigned AGE_W  = 8;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [AGE_W-1:0]  age;
    } entry_t;

endpackage

// File: rtl/sram_like_resp_fifo.sv
// In-order response FIFO; each entry ages down to zero and the head is offered once aged out.
module sram_like_resp_fifo
    import sram_like_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LATENCY = 2,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              head_ready_c,
    output logic [DATA_W-1:0] head_data_c,
    output logic [CNT_W-1:0]  count_c
);

    entry_t           entries [DEPTH];
    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] rd_idx;

    assign wr_idx       = wr_ptr[PTR_W-1:0];
    assign rd_idx       = rd_ptr[PTR_W-1:0];
    assign count_c      = wr_ptr - rd_ptr;
    assign head_data_c  = entries[rd_idx].data;
    assign head_ready_c = (count_c != '0) && (entries[rd_idx].age == '0);

    // Pointers wrap modulo DEPTH; the extra MSB separates full from empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + CNT_W'(1);
            end
        end
    end

    // Entry payloads and ages; occupancy lives in the pointers so no reset is needed here.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (entries[i].age != '0) begin
                entries[i].age <= entries[i].age - AGE_W'(1);
            end
        end
        if (push) begin
            entries[wr_idx] <= '{data: push_data, age: AGE_W'(LATENCY - 1)};
        end
    end

endmodule

// File: rtl/sram_like_slave.sv
// Fixed-latency, in-order SRAM-like responder backed by a word-addressed RAM.
module sram_like_slave
    import sram_like_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned MEM_AW    = 12,
    parameter string       INIT_FILE = "",
    localparam int unsigned CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic [3:0]        wstrb,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              addr_ok,
    output logic              data_ok,
    output logic [31:0]       rdata,
    input  logic              hold_addr,
    output logic [CNT_W-1:0]  outstanding
);

    localparam int unsigned WORDS = 1 << MEM_AW;

    // No preload path in this model: RAM contents come from writes only.
    localparam bit unused_init_file = (INIT_FILE != "");

    logic [DATA_W-1:0] ram [WORDS];
    logic [MEM_AW-1:0] ram_idx;
    logic              hs_c;
    logic [DATA_W-1:0] push_data_c;
    logic              head_ready_c;
    logic [DATA_W-1:0] head_data_c;
    logic [DATA_W-1:0] rdata_q;

    // Size and the byte offset do not affect the RAM access: lanes come from wstrb, reads are whole words.
    logic unused_inputs;
    assign unused_inputs = ^{size, addr[31:MEM_AW+2], addr[1:0]};

    assign ram_idx     = addr[MEM_AW+1:2];
    assign addr_ok     = ~reset & ~hold_addr & (outstanding < CNT_W'(DEPTH));
    assign hs_c        = req & addr_ok;
    assign push_data_c = wr ? '0 : ram[ram_idx];
    assign data_ok     = ~reset & head_ready_c;
    assign rdata       = data_ok ? head_data_c : rdata_q;

    // Response queue; the head pops in every data_ok cycle.
    sram_like_resp_fifo #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) u_resp_fifo (
        .clk          (clk),
        .reset        (reset),
        .push         (hs_c),
        .push_data    (push_data_c),
        .pop          (data_ok),
        .head_ready_c (head_ready_c),
        .head_data_c  (head_data_c),
        .count_c      (outstanding)
    );

    // Keep the last delivered response on rdata between pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (data_ok) begin
            rdata_q <= head_data_c;
        end
    end

    // Byte-enabled write commit at the end of the handshake cycle; RAM survives reset.
    always_ff @(posedge clk) begin
        if (hs_c && wr) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    ram[ram_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_like_slave.sv
// Bench for sram_like_slave: directed vector table, multi-cycle sequences, and a
// randomized run checked against a due-time reference model.
module tb_sram_like_slave;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LAT   = 2;
    localparam int unsigned LAT8  = 8;
    localparam int unsigned CW    = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic        hold_addr = 1'b0;
    logic [1:0]  size = 2'd0;
    logic [3:0]  wstrb = 4'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;

    logic          addr_ok, data_ok;
    logic [31:0]   rdata;
    logic [CW-1:0] outstanding;
    logic          addr_ok8, data_ok8;
    logic [31:0]   rdata8;
    logic [CW-1:0] outstanding8;

    sram_like_slave #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok),
        .rdata(rdata), .hold_addr(hold_addr), .outstanding(outstanding)
    );

    sram_like_slave #(.DEPTH(DEPTH), .LATENCY(LAT8)) u_dut_l8 (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .addr_ok(addr_ok8), .data_ok(data_ok8),
        .rdata(rdata8), .hold_addr(hold_addr), .outstanding(outstanding8)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // ---------------- reference model (main DUT, LATENCY=2) ----------------
    typedef struct {
        logic [31:0] data;
        bit          known;
        longint      due;
    } exp_t;

    exp_t        mq [$];
    logic [31:0] mm [4096];
    bit          mk [4096];
    logic [31:0] m_last = 32'd0;
    bit          m_last_known = 1'b1;
    longint      cyc = 0;

    always @(negedge clk) begin : ref_model
        exp_t e;
        bit   e_aok;
        bit   e_dok;
        int   idx;
        cyc++;
        if (reset) begin
            chk1("m_rst_addr_ok", addr_ok, 1'b0);
            chk1("m_rst_data_ok", data_ok, 1'b0);
            mq.delete();
            m_last       = 32'd0;
            m_last_known = 1'b1;
        end else begin
            e_aok = !hold_addr && (mq.size() < int'(DEPTH));
            e_dok = (mq.size() != 0) && (cyc >= mq[0].due);
            chk("m_outstanding", 32'(outstanding), 32'(mq.size()));
            chk1("m_addr_ok", addr_ok, e_aok);
            chk1("m_data_ok", data_ok, e_dok);
            if (e_dok) begin
                if (mq[0].known) chk("m_rdata", rdata, mq[0].data);
                m_last       = mq[0].data;
                m_last_known = mq[0].known;
                void'(mq.pop_front());
            end else if (m_last_known) begin
                chk("m_rdata_hold", rdata, m_last);
            end
            if (req && e_aok) begin
                idx   = int'(addr[13:2]);
                e.due = cyc + longint'(LAT);
                if (wr) begin
                    e.data  = 32'd0;
                    e.known = 1'b1;
                    for (int b = 0; b < 4; b++)
                        if (wstrb[b]) mm[idx][8*b +: 8] = wdata[8*b +: 8];
                    if (wstrb == 4'hF) mk[idx] = 1'b1;
                end else begin
                    e.data  = mm[idx];
                    e.known = mk[idx];
                end
                mq.push_back(e);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drv(input logic r, input logic w, input logic h, input logic [1:0] s,
                       input logic [3:0] st, input logic [31:0] a, input logic [31:0] d);
        req = r; wr = w; hold_addr = h; size = s; wstrb = st; addr = a; wdata = d;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 32'd0, 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        req, wr, hold;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr, wdata;
        logic        e_aok, e_dok;
        logic [31:0] e_rd;
    } vec_t;

    localparam int NV = 19;
    vec_t tbl [NV];

    function automatic vec_t v(input logic r, input logic w, input logic h, input logic [1:0] s,
                               input logic [3:0] st, input logic [31:0] a, input logic [31:0] d,
                               input logic ea, input logic ed, input logic [31:0] er);
        vec_t x;
        x.req = r; x.wr = w; x.hold = h; x.size = s; x.wstrb = st; x.addr = a; x.wdata = d;
        x.e_aok = ea; x.e_dok = ed; x.e_rd = er;
        return x;
    endfunction

    logic [31:0] rnd;
    logic        acc;
    logic        need_new;

    initial begin
        //            req  wr   hold size  wstrb  addr           wdata          aok  dok  rdata
        tbl[0]  = v(1'b1,1'b1,1'b0,2'd2,4'hF,32'h0000_0040,32'hDEAD_BEEF,1'b1,1'b0,32'h0);
        tbl[1]  = v(1'b1,1'b1,1'b0,2'd2,4'hF,32'h0000_0044,32'hAABB_CCDD,1'b1,1'b0,32'h0);
        tbl[2]  = v(1'b0,1'b0,1'b0,2'd0,4'h0,32'h0,        32'h0,        1'b1,1'b1,32'h0);
        tbl[3]  = v(1'b1,1'b0,1'b0,2'd2,4'h0,32'h0000_0040,32'h0,        1'b1,1'b1,32'h0);
        tbl[4]  = v(1'b0,1'b0,1'b0,2'd0,4'h0,32'h0,        32'h0,        1'b1,1'b0,32'h0);
        tbl[5]  = v(1'b0,1'b0,1'b0,2'd0,4'h0,32'h0,        32'h0,        1'b1,1'b1,32'hDEAD_BEEF);
        tbl[6]  = v(1'b0,1'b0,1'b0,2'd0,4'h0,32'h0,        32'h0,        1'b1,1'b0,32'hDEAD_BEEF);
        tbl[7]  = v(1'b1,1'b1,1'b0,2'd2,4'h5,32'h0000_0044,32'h1122_3344,1'b1,1'b0,32'hDEAD_BEEF);
        tbl[8]  = v(1'b1,1'b0,1'b0,2'd2,4'h0,32'h0000_0044,32'h0,        1'b1,1'b0,32'hDEAD_BEEF);
        tbl[9]  = v(1'b0,1'b0,1'b0,2'd0,4'h0,32'h0,        32'h0,        1'b1,1'b1,32'h0);
        tbl[10] = v(1'b0,1'b0,1'b0,2'd0,4'h0,32'h0,        32'h0,        1'b1,1'b1,32'hAA22_CC44);
        tbl[11] = v(1'b0,1'b0,1'b0,2'd0,4'h0,32'h0,        32'h0,        1'b1,1'b0,32'hAA22_CC44);
        tbl[12] = v(1'b1,1'b0,1'b1,2'd2,4'h0,32'h0000_0040,32'h0,        1'b0,1'b0,32'hAA22_CC44);
        tbl[13] = v(1'b1,1'b0,1'b0,2'd2,4'h0,32'h0000_0040,32'h0,        1'b1,1'b0,32'hAA22_CC44);
        tbl[14] = v(1'b0,1'b0,1'b0,2'd0,4'h0,32'h0,        32'h0,        1'b1,1'b0,32'hAA22_CC44);
        tbl[15] = v(1'b0,1'b0,1'b0,2'd0,4'h0,32'h0,        32'h0,        1'b1,1'b1,32'hDEAD_BEEF);
        tbl[16] = v(1'b1,1'b0,1'b0,2'd0,4'h0,32'hFFFF_0043,32'h0,        1'b1,1'b0,32'hDEAD_BEEF);
        tbl[17] = v(1'b0,1'b0,1'b0,2'd0,4'h0,32'h0,        32'h0,        1'b1,1'b0,32'hDEAD_BEEF);
        tbl[18] = v(1'b0,1'b0,1'b0,2'd0,4'h0,32'h0,        32'h0,        1'b1,1'b1,32'hDEAD_BEEF);

        // Power-on reset: two edges.
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single read, write-merge and hold_addr cases from the table.
        for (int i = 0; i < NV; i++) begin
            drv(tbl[i].req, tbl[i].wr, tbl[i].hold, tbl[i].size, tbl[i].wstrb, tbl[i].addr, tbl[i].wdata);
            @(negedge clk);
            chk1($sformatf("vec%0d_addr_ok", i), addr_ok, tbl[i].e_aok);
            chk1($sformatf("vec%0d_data_ok", i), data_ok, tbl[i].e_dok);
            chk($sformatf("vec%0d_rdata", i), rdata, tbl[i].e_rd);
            step();
        end
        idle();

        // Prefill words 0..9 for streaming.
        for (int i = 0; i < 10; i++) begin
            drv(1'b1, 1'b1, 1'b0, 2'd2, 4'hF, 32'(i * 4), 32'hC0DE_0000 + 32'(i));
            step();
        end
        idle();
        repeat (4) step();

        // Streaming: 10 back-to-back reads give 10 back-to-back responses in order.
        for (int k = 0; k < 13; k++) begin
            if (k < 10) drv(1'b1, 1'b0, 1'b0, 2'd2, 4'h0, 32'(k * 4), 32'd0);
            else idle();
            @(negedge clk);
            chk1("stream_data_ok", data_ok, (k >= 2) && (k < 12));
            if ((k >= 2) && (k < 12)) chk("stream_rdata", rdata, 32'hC0DE_0000 + 32'(k - 2));
            step();
        end
        idle();

        // hold_addr blocks acceptance while three reads still drain.
        for (int k = 0; k < 7; k++) begin
            if (k < 3) drv(1'b1, 1'b0, 1'b0, 2'd2, 4'h0, 32'(k * 4), 32'd0);
            else drv(1'b1, 1'b0, 1'b1, 2'd2, 4'h0, 32'h0000_000C, 32'd0);
            @(negedge clk);
            if (k >= 3) chk1("hold_addr_ok", addr_ok, 1'b0);
            chk1("hold_data_ok", data_ok, (k >= 2) && (k <= 4));
            if ((k >= 2) && (k <= 4)) chk("hold_rdata", rdata, 32'hC0DE_0000 + 32'(k - 2));
            if (k >= 5) chk("hold_outstanding", 32'(outstanding), 32'd0);
            step();
        end
        idle();

        // Fill to full on the LATENCY=8 instance; no refill in the pop cycle.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            drv(1'b1, 1'b0, 1'b0, 2'd2, 4'h0, 32'h0000_0040, 32'd0);
            @(negedge clk);
            chk1("full_addr_ok8", addr_ok8, (k < 4) || (k == 9));
            chk("full_outstanding8", 32'(outstanding8), (k < 4) ? 32'(k) : ((k <= 8) ? 32'd4 : 32'd3));
            chk1("full_data_ok8", data_ok8, (k == 8) || (k == 9));
            if (k == 8) chk("full_rdata8", rdata8, 32'hDEAD_BEEF);
            step();
        end
        idle();

        // Reset with three outstanding on the LATENCY=8 instance; accepted write survives.
        do_reset();
        drv(1'b1, 1'b1, 1'b0, 2'd2, 4'hF, 32'h0000_0080, 32'h1234_5678);
        step();
        idle();
        repeat (10) step();
        drv(1'b1, 1'b1, 1'b0, 2'd0, 4'b0001, 32'h0000_0080, 32'h0000_005A);
        @(negedge clk);
        chk1("rstmid_wr_addr_ok8", addr_ok8, 1'b1);
        step();
        drv(1'b1, 1'b0, 1'b0, 2'd2, 4'h0, 32'h0000_0040, 32'd0);
        step();
        drv(1'b1, 1'b0, 1'b0, 2'd2, 4'h0, 32'h0000_0044, 32'd0);
        step();
        idle();
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_pre_outstanding8", 32'(outstanding8), 32'd3);
        chk1("rstmid_rst_data_ok8", data_ok8, 1'b0);
        chk1("rstmid_rst_addr_ok8", addr_ok8, 1'b0);
        step();
        reset = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            chk1("rstmid_no_data_ok8", data_ok8, 1'b0);
            if (j == 0) chk("rstmid_outstanding8", 32'(outstanding8), 32'd0);
            step();
        end
        for (int k = 0; k < 9; k++) begin
            if (k == 0) drv(1'b1, 1'b0, 1'b0, 2'd2, 4'h0, 32'h0000_0080, 32'd0);
            else idle();
            @(negedge clk);
            chk1("rstmid_rd_data_ok8", data_ok8, k == 8);
            if (k == 8) begin
                chk("rstmid_rd_word8", rdata8, 32'h1234_565A);
                chk("rstmid_rd_byte0", 32'(rdata8[7:0]), 32'h5A);
            end
            step();
        end
        idle();

        // Randomized traffic against the reference model; request held until accepted.
        do_reset();
        need_new = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if (need_new) begin
                rnd   = $urandom;
                req   = ($urandom_range(0, 3) != 0);
                wr    = ($urandom_range(0, 2) == 0);
                size  = 2'($urandom_range(0, 2));
                wstrb = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
                addr  = {rnd[31:14], 6'd0, 6'($urandom_range(0, 63)), rnd[1:0]};
                wdata = $urandom;
            end
            hold_addr = ($urandom_range(0, 7) == 0);
            reset     = ($urandom_range(0, 199) == 0);
            @(negedge clk);
            acc      = req && addr_ok;
            need_new = !req || acc || reset;
            step();
        end
        reset = 1'b0;
        idle();
        repeat (6) step();
        @(negedge clk);
        chk("final_outstanding", 32'(outstanding), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
